alu_cmd_sequencer: RTL and testbench

- Hardware stimulus driver and result collector for the team's registered 4-function ALU (operands A and B, 2-bit select S, registered `out`).
- Accepts operation commands on a valid/ready request channel and drives the operands and select to the ALU, holding them stable.
- Waits the ALU's fixed latency, captures the result, and returns it with the command tag on a valid/ready response channel.
- Sits between a command source (CPU/test controller) and the ALU, in place of bench-driven stimulus.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/rst_sync.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types for the ALU command sequencer: FSM state
//               encoding, ALU select width and command/response records.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // ALU select width and the default datapath/tag widths of the records
    localparam int c_ALU_SEL_W = 2;
    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_TAG_W = 4;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command as presented on the request channel
    typedef struct packed {
        logic [c_DEF_WIDTH-1:0] a;
        logic [c_DEF_WIDTH-1:0] b;
        logic [c_ALU_SEL_W-1:0] sel;
        logic [c_DEF_TAG_W-1:0] tag;
    } cmd_t;

    // Response as returned on the response channel
    typedef struct packed {
        logic [c_DEF_WIDTH-1:0] data;
        logic [c_DEF_TAG_W-1:0] tag;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync
// Description : Two-flop reset synchroniser. Assertion is asynchronous and
//               immediate; deassertion is released after two clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync (
    input  logic clk,
    input  logic i_arst_n,
    output logic o_rst_n
);

    logic r_meta;
    logic r_sync;

    // Shift a one through two flops after the async reset lifts
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Drives one command at a time into a registered ALU, waits its
//               fixed latency, and returns the captured result with the tag
//               on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int SEL_W   = c_ALU_SEL_W,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = c_DEF_TAG_W,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    // Counter must be able to hold ALU_LAT
    localparam int c_LAT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    logic               w_rst_n;
    state_t             r_state;
    state_t             w_next_state;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [SEL_W-1:0]   r_alu_sel;
    logic [TAG_W-1:0]   r_cmd_tag;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [CNT_W-1:0]   r_done_count;
    logic               w_accept;
    logic               w_capture;
    logic               w_retire;

    rst_sync u_rst_sync (
        .clk      (clk),
        .i_arst_n (reset),
        .o_rst_n  (w_rst_n)
    );

    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_capture = (r_state == WAIT) && (r_lat_cnt == '0);
    assign w_retire  = (r_state == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one outstanding command, IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = WAIT;
            WAIT:    if (w_capture) w_next_state = RESP;
            RESP:    if (w_retire)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        rsp_valid = (r_state == RESP);
    end

    // Datapath: operands only move on accept so the ALU sees stable inputs
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_cmd_tag    <= '0;
            r_lat_cnt    <= '0;
            r_rsp_data   <= '0;
            r_rsp_tag    <= '0;
            r_done_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= cmd_a;
                r_alu_b   <= cmd_b;
                r_alu_sel <= cmd_sel;
                r_cmd_tag <= cmd_tag;
                r_lat_cnt <= c_LAT_W'(ALU_LAT);
            end
            if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end
            if (w_capture) begin
                r_rsp_data <= alu_out;
                r_rsp_tag  <= r_cmd_tag;
            end
            if (w_retire) begin
                r_done_count <= r_done_count + CNT_W'(1);
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a registered
//               ALU stub (out <= A ^ B ^ S) and a behavioural result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int WIDTH   = 32;
    localparam int SEL_W   = 2;
    localparam int ALU_LAT = 1;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [SEL_W-1:0] cmd_sel;
    logic [TAG_W-1:0] cmd_tag;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               last_retire;
    logic [CNT_W-1:0] exp_done;

    alu_cmd_sequencer #(
        .WIDTH   (WIDTH),
        .SEL_W   (SEL_W),
        .ALU_LAT (ALU_LAT),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // Registered ALU stub, one cycle of latency
    always @(posedge clk) alu_out <= alu_a ^ alu_b ^ {{(WIDTH-SEL_W){1'b0}}, alu_sel};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result of one command
    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [SEL_W-1:0] s);
        return a ^ b ^ WIDTH'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge, optionally stall the response and push
    // a competing command during the stall; returns at the negedge after retire.
    task automatic run_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [SEL_W-1:0] s, input logic [TAG_W-1:0] t,
                           input int stall, input bit push);
        int w;
        int acc;
        logic [WIDTH-1:0] exp_data;
        exp_data  = alu_ref(a, b, s);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        cmd_tag   = t;
        rsp_ready = (stall == 0);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
        if (last_retire >= 0) chk("accept_gap", acc - last_retire, 1);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, s);
        chk("busy_wait", busy, 1);
        chk("cmd_ready_wait_state", cmd_ready, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 50);
        chk("rsp_latency", w, ALU_LAT + 1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_tag", rsp_tag, t);
        for (int i = 0; i < stall; i++) begin
            if (push && i == 0) begin
                cmd_valid = 1'b1;
                cmd_a     = 1;
                cmd_b     = 1;
                cmd_sel   = 2;
                cmd_tag   = 9;
            end
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, exp_data);
            chk("stall_tag", rsp_tag, t);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_alu_a", alu_a, a);
            chk("stall_alu_b", alu_b, b);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        last_retire = cyc;
        exp_done    = exp_done + 1'b1;
        chk("retire_valid", rsp_valid, 0);
        chk("done_count", done_count, exp_done);
        chk("retire_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_sel     = '0;
        cmd_tag     = '0;
        rsp_ready   = 1'b0;
        exp_done    = '0;
        last_retire = -1;

        // Reset and release
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_done_count", done_count, 0);

        // Single command
        run_cmd(32'd6, 32'd3, 2'd0, 4'd5, 0, 1'b0);

        // Four back-to-back commands over all selects
        for (int i = 0; i < 4; i++) run_cmd(32'd6, 32'd3, SEL_W'(i), TAG_W'(i), 0, 1'b0);

        // Response stall with a competing command held on the request side
        run_cmd(32'd10, 32'd12, 2'd1, 4'd3, 10, 1'b1);
        run_cmd(32'd1, 32'd1, 2'd2, 4'd9, 0, 1'b0);

        // Reset pulse while a command is in flight
        cmd_valid = 1'b1;
        cmd_a     = 32'h1234;
        cmd_b     = 32'h00ff;
        cmd_sel   = 2'd3;
        cmd_tag   = 4'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("inflight_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_sel", alu_sel, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_rsp_tag", rsp_tag, 0);
        chk("arst_done_count", done_count, 0);
        #2;
        reset    = 1'b1;
        exp_done = '0;
        seen     = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("dropped_no_rsp", seen, 0);
        chk("post_arst_done", done_count, 0);
        last_retire = -1;

        // Counter wrap
        force dut.r_done_count = 16'hFFFF;
        #1;
        release dut.r_done_count;
        @(negedge clk);
        exp_done = 16'hFFFF;
        chk("forced_done", done_count, 16'hFFFF);
        run_cmd(32'd2, 32'd5, 2'd1, 4'd4, 0, 1'b0);

        // Randomized commands with random response back-pressure
        for (int i = 0; i < 20; i++) begin
            run_cmd($urandom, $urandom, SEL_W'($urandom_range(0, 3)),
                    TAG_W'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
